// File: rtl/addsub_flags_seq_if.sv
// Request/response bundle for the sequential adder/subtractor: the control
// unit drives the request side, the datapath answers with status and result.
interface addsub_flags_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             sig_N;
    logic             sig_Z;
    logic             sig_C;
    logic             sig_O;

    modport master (
        output start, op, a, b, c_in,
        input  busy, done, s, sig_N, sig_Z, sig_C, sig_O
    );

    modport slave (
        input  start, op, a, b, c_in,
        output busy, done, s, sig_N, sig_Z, sig_C, sig_O
    );
endinterface

// File: rtl/addsub_flags_seq.sv
// Multi-cycle add/subtract with N/Z/C/O flags: CHUNK bits per clock from the
// LSB upward, carry held in a register between chunks.
module addsub_flags_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    addsub_flags_seq_if.slave bus
);
    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("addsub_flags_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  beff_q, beff_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              zacc_q, zacc_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              n_q, n_d, z_q, z_d, c_q, c_d, o_q, o_d;

    logic [CHUNK-1:0]  a_ch [NCH];
    logic [CHUNK-1:0]  b_ch [NCH];
    logic [CHUNK:0]    chunk_sum;
    logic [CHUNK-1:0]  part;
    logic [WIDTH-1:0]  sum_full;

    // Working sum with the current chunk already merged in, so the last RUN
    // edge can publish the complete result without an extra cycle.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
        assign a_ch[gi] = a_q[gi*CHUNK +: CHUNK];
        assign b_ch[gi] = beff_q[gi*CHUNK +: CHUNK];
        assign sum_full[gi*CHUNK +: CHUNK] =
            (idx_q == IDXW'(gi)) ? part : sum_q[gi*CHUNK +: CHUNK];
    end

    assign chunk_sum = {1'b0, a_ch[idx_q]} + {1'b0, b_ch[idx_q]}
                     + {{CHUNK{1'b0}}, carry_q};
    assign part      = chunk_sum[CHUNK-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            beff_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            beff_q  <= beff_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            o_q     <= o_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        beff_d  = beff_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        zacc_d  = zacc_q;
        idx_d   = idx_q;
        s_d     = s_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        o_d     = o_q;
        unique case (state_q)
            IDLE, DONE: begin
                // Subtraction is a + ~b + ~borrow_in on the same adder.
                if (bus.start) begin
                    a_d     = bus.a;
                    beff_d  = bus.op ? ~bus.b : bus.b;
                    carry_d = bus.op ? ~bus.c_in : bus.c_in;
                    idx_d   = '0;
                    zacc_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                carry_d = chunk_sum[CHUNK];
                zacc_d  = zacc_q | (|part);
                sum_d   = sum_full;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    s_d     = sum_full;
                    n_d     = sum_full[WIDTH-1];
                    z_d     = ~(zacc_q | (|part));
                    c_d     = chunk_sum[CHUNK];
                    o_d     = (a_q[WIDTH-1] == beff_q[WIDTH-1])
                            & (sum_full[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.s     = s_q;
    assign bus.sig_N = n_q;
    assign bus.sig_Z = z_q;
    assign bus.sig_C = c_q;
    assign bus.sig_O = o_q;
endmodule

// File: tb/tb_addsub_flags_seq.sv
// Self-checking bench: two instances (CHUNK=8 and CHUNK=32) against an
// arithmetic reference model, directed corner cases plus random operations.
module tb_addsub_flags_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_flags_seq_if #(.WIDTH(32)) bus8 ();
    addsub_flags_seq_if #(.WIDTH(32)) bus32 ();

    addsub_flags_seq #(.WIDTH(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave)
    );
    addsub_flags_seq #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic st, input logic op,
                          input logic [31:0] a, input logic [31:0] b, input logic cin);
        if (sel == 0) begin
            bus8.start = st; bus8.op = op; bus8.a = a; bus8.b = b; bus8.c_in = cin;
        end else begin
            bus32.start = st; bus32.op = op; bus32.a = a; bus32.b = b; bus32.c_in = cin;
        end
    endtask

    // f = {N, Z, C, O}
    task automatic get_out(input int sel, output logic busy, output logic done,
                           output logic [31:0] s, output logic [3:0] f);
        if (sel == 0) begin
            busy = bus8.busy; done = bus8.done; s = bus8.s;
            f = {bus8.sig_N, bus8.sig_Z, bus8.sig_C, bus8.sig_O};
        end else begin
            busy = bus32.busy; done = bus32.done; s = bus32.s;
            f = {bus32.sig_N, bus32.sig_Z, bus32.sig_C, bus32.sig_O};
        end
    endtask

    // Reference: true integer arithmetic, then read the flags off the result.
    task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, output logic [31:0] s, output logic [3:0] f);
        longint ext, sgn;
        logic [63:0] e;
        if (op) begin
            ext = 64'sh1_0000_0000 + longint'(a) - longint'(b) - longint'(cin);
            sgn = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
        end else begin
            ext = longint'(a) + longint'(b) + longint'(cin);
            sgn = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        e = ext;
        s = e[31:0];
        f = {s[31], (s == 32'h0), e[32],
             (sgn > 64'sd2147483647) || (sgn < -64'sd2147483648)};
    endtask

    // Waits for done; latency counted in negedges after the accepting edge.
    task automatic wait_done(input int sel, input int exp_lat, input string tag,
                             output logic [31:0] s, output logic [3:0] f);
        logic busy, done;
        int cnt, nbusy;
        nbusy = 0;
        cnt = 0;
        done = 1'b0;
        while (!done && cnt < 40) begin
            @(negedge clk);
            cnt++;
            get_out(sel, busy, done, s, f);
            if (busy) nbusy++;
        end
        check({tag, "_latency"}, 64'(cnt), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
    endtask

    task automatic do_op(input int sel, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input string tag);
        logic [31:0] es, os;
        logic [3:0]  ef, of;
        model(op, a, b, cin, es, ef);
        @(negedge clk);
        set_in(sel, 1'b1, op, a, b, cin);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, ~op, $urandom, $urandom, ~cin);
        wait_done(sel, (sel == 0) ? 5 : 2, tag, os, of);
        check({tag, "_s"}, 64'(os), 64'(es));
        check({tag, "_NZCO"}, 64'(of), 64'(ef));
        $display("op %s sel=%0d op=%0d a=%h b=%h cin=%0d -> s=%h NZCO=%b (exp %h %b)",
                 tag, sel, op, a, b, cin, os, of, es, ef);
    endtask

    initial begin
        logic busy, done;
        logic [31:0] s, es, es2, s_before;
        logic [3:0]  f, ef, ef2;
        int ndone;

        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_in(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #3;
        get_out(0, busy, done, s, f);
        check("reset_busy_done", 64'({busy, done}), 64'd0);
        check("reset_s_flags", 64'({s, f}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases
        do_op(0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, "add_zero");
        do_op(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, "add_wrap");
        do_op(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1, "add_wrap_cin");
        do_op(0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ovf");
        do_op(0, 1'b1, 32'h0000_0005, 32'h0000_0005, 1'b0, "sub_eq");
        do_op(0, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, "sub_borrow");
        do_op(0, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, "sub_ovf");
        do_op(0, 1'b1, 32'h0000_00FF, 32'h0000_00FF, 1'b1, "sub_bin");

        // Back-to-back: start held high through RUN and DONE
        model(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, es, ef);
        model(1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, es2, ef2);
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
        @(posedge clk);
        #1;
        set_in(0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0);
        wait_done(0, 5, "b2b_first", s, f);
        check("b2b_first_s", 64'(s), 64'(es));
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_done(0, 5, "b2b_second", s, f);
        check("b2b_second_s", 64'(s), 64'(es2));
        check("b2b_second_NZCO", 64'(f), 64'(ef2));
        $display("op b2b second s=%h NZCO=%b (exp %h %b)", s, f, es2, ef2);

        // Start pulsed mid-RUN is ignored
        model(1'b0, 32'h0000_00F0, 32'h0000_0010, 1'b0, es, ef);
        get_out(0, busy, done, s_before, f);
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 32'h0000_00F0, 32'h0000_0010, 1'b0);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        set_in(0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        get_out(0, busy, done, s, f);
        check("midrun_s_held", 64'(s), 64'(s_before));
        check("midrun_busy", 64'({busy, done}), 64'b10);
        wait_done(0, 2, "midrun", s, f);
        check("midrun_s", 64'(s), 64'(es));
        check("midrun_NZCO", 64'(f), 64'(ef));
        $display("op midrun s=%h NZCO=%b (exp %h %b)", s, f, es, ef);

        // Asynchronous reset during RUN cycle 2
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        get_out(0, busy, done, s, f);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_s_flags", 64'({s, f}), 64'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            get_out(0, busy, done, s, f);
            if (done) ndone++;
        end
        check("rst_no_done", 64'(ndone), 64'd0);
        rst_n = 1'b1;
        $display("op reset_mid_run ndone=%0d", ndone);
        do_op(0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "after_rst");

        // Single-chunk instance
        do_op(1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "c32_add_ovf");
        do_op(1, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, "c32_sub_borrow");

        // Random operations on both instances, biased toward chunk edges
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = ra | 32'h00FF_FF00;
            if (i % 4 == 2) rb = ~ra;
            do_op(i % 2, 1'(($urandom)), ra, rb, 1'(($urandom)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/addsub_flags_seq.md
Name: addsub_flags_seq

Overview:
- Parametrised, multi-cycle adder/subtractor with full N/Z/C/O status flags. It is the sequential successor of the 32-bit ripple-carry flag adder.
- Processes CHUNK bits per clock, from the LSB chunk upward, using a registered inter-chunk carry. This trades latency for a short carry chain.
- Sits in the datapath ALU slot. It is driven by the control unit through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- CHUNK, 8, bits added per cycle. WIDTH % CHUNK must equal 0; otherwise elaboration fails.
- NCH (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  1  0 = add (a+b+c_in), 1 = subtract (a−b−c_in).
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- c_in  input  1  carry-in (add) / borrow-in (sub); latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when s and the flags become valid.
- s  output  WIDTH  result register.
- sig_N  output  1  s[WIDTH−1].
- sig_Z  output  1  s == 0.
- sig_C  output  1  carry out of the MSB. For sub this means 1 = no borrow.
- sig_O  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy = done = 0; s = 0; all flags = 0; internal carry, chunk index and operand registers cleared. Reset mid-RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge → latch a, op, c_in, and b_eff = op ? ~b : b. Set carry = op ? ~c_in : c_in, idx = 0, Z-accumulator = 0, go to RUN.
  - RUN: each edge, for chunk idx:
    - {cy, part} = a_chunk + b_eff_chunk + carry, all CHUNK+1 bits wide.
    - Store part into the working sum at idx*CHUNK; carry ← cy.
    - zacc ← zacc | (|part).
    - idx ← idx+1.
    - On the edge that processes idx = NCH−1, go to DONE.
  - DONE: lasts exactly one cycle with done = 1. On entry, s, sig_N, sig_Z (= ~zacc_final), sig_C (= final carry) and sig_O are updated together. start=1 in DONE is accepted as in IDLE (back-to-back), going to RUN; otherwise go to IDLE.
- start while busy is ignored: no restart, no queueing.
- Latency: done is high in the cycle after the NCH-th edge following the accepting edge. Default configuration: 4 cycles. With CHUNK = WIDTH: 1 cycle.
- Throughput: one operation per NCH+1 cycles.
- s and the flags hold their last values through IDLE and RUN. They change only on entry to DONE.
- Overflow: sig_O = (a[MSB] == b_eff[MSB]) & (s[MSB] != a[MSB]), evaluated on the full latched operands and final sum.
- Subtract is a + ~b + ~c_in. For example, 5−5 with c_in=0 gives carry 1.
- Width: all arithmetic is modulo 2^WIDTH. The carry out of the MSB goes only to sig_C.
- Inputs a, b, op and c_in may change freely after the accepting edge without affecting the operation in flight.

Test Plan:
1. WIDTH=32/CHUNK=8, add 0x00000000+0x00000000, c_in=0 → after 4 cycles: done pulse, s=0, Z=1, N=0, C=0, O=0. busy is high for exactly 4 cycles.
2. Add 0xFFFFFFFF+0x00000003, c_in=0 → s=0x00000002, C=1, Z=0, N=0, O=0. Repeat with c_in=1 → s=0x00000003.
3. Add 0x7FFFFFFF+0x00000001 → s=0x80000000, N=1, O=1, C=0, Z=0.
4. Sub 5−5, c_in=0 → s=0, Z=1, C=1, O=0. Then sub 0−1 → s=0xFFFFFFFF, N=1, C=0, O=0. Then sub 0x80000000−1 → s=0x7FFFFFFF, O=1, C=1.
5. Back-to-back: start held high across DONE → second operation accepted in the DONE cycle and its done arrives 5 cycles after the first. start pulsed mid-RUN → ignored; s is unchanged until the current done.
6. rst_n low during RUN cycle 2 → busy=0, s=0, all flags=0 immediately (asynchronous). No done is produced. A new start after release completes normally. Repeat scenario 3 with CHUNK=32 → done 1 cycle after start.
